// File: rtl/cook_timer_ctrl_if.sv
// Keypad, command, door and display/status signals of the cook timer.
// The master side (keypad panel and door switch) drives commands; the slave side (timer controller) drives the display and status.
interface cook_timer_ctrl_if;
  logic       keypad_valid;
  logic [3:0] keypad_digit;
  logic       start;
  logic       stop;
  logic       clear;
  logic       door_closed;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min;
  logic       mag_on;
  logic       done;
  logic [1:0] state;

  modport master (
    output keypad_valid, keypad_digit, start, stop, clear, door_closed,
    input  sec_ones, sec_tens, min, mag_on, done, state
  );

  modport slave (
    input  keypad_valid, keypad_digit, start, stop, clear, door_closed,
    output sec_ones, sec_tens, min, mag_on, done, state
  );
endinterface

// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer: BCD M:SS entry by keypad, 1 s countdown, door interlock and magnetron enable.
// Every output comes straight from a register.
module cook_timer_ctrl #(
  parameter int TICKS_PER_SEC = 100
) (
  input logic              clk,
  input logic              reset,
  cook_timer_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COOKING = 2'd1,
    S_PAUSED  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [3:0]    r_ones, r_tens, r_min;
  logic [3:0]    w_ones_next, w_tens_next, w_min_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic          r_mag_on, r_done;

  logic [3:0]    w_dec_ones, w_dec_tens, w_dec_min;
  logic          w_borrow_ones, w_borrow_tens;
  logic          w_dec_zero, w_time_nz, w_tick, w_key_ok;

  // BCD decrement of M:SS; seconds tens wraps 0 -> 5.
  always_comb begin
    w_borrow_ones = (r_ones == 4'd0);
    w_dec_ones    = w_borrow_ones ? 4'd9 : r_ones - 4'd1;
    w_dec_tens    = r_tens;
    w_borrow_tens = 1'b0;
    if (w_borrow_ones) begin
      if (r_tens == 4'd0) begin
        w_dec_tens    = 4'd5;
        w_borrow_tens = 1'b1;
      end else begin
        w_dec_tens = r_tens - 4'd1;
      end
    end
    w_dec_min  = w_borrow_tens ? r_min - 4'd1 : r_min;
    w_dec_zero = ({w_dec_min, w_dec_tens, w_dec_ones} == 12'h000);
  end

  assign w_time_nz = |{r_min, r_tens, r_ones};
  assign w_tick    = (r_presc == LAST_TICK);
  assign w_key_ok  = bus.keypad_valid && (bus.keypad_digit <= 4'd9);

  always_comb begin
    w_state_next = r_state;
    w_ones_next  = r_ones;
    w_tens_next  = r_tens;
    w_min_next   = r_min;
    w_presc_next = r_presc;
    case (r_state)
      S_IDLE: begin
        if (bus.clear) begin
          {w_min_next, w_tens_next, w_ones_next} = 12'h000;
        end else if (bus.start && bus.door_closed && w_time_nz) begin
          w_state_next = S_COOKING;
          w_presc_next = '0;
        end else if (w_key_ok) begin
          w_min_next  = r_tens;
          w_tens_next = r_ones;
          w_ones_next = bus.keypad_digit;
        end
      end
      S_COOKING: begin
        if (bus.clear) begin
          w_state_next = S_IDLE;
          w_presc_next = '0;
          {w_min_next, w_tens_next, w_ones_next} = 12'h000;
        end else if (!bus.door_closed || bus.stop) begin
          w_state_next = S_PAUSED;
        end else begin
          w_presc_next = w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) begin
            w_min_next  = w_dec_min;
            w_tens_next = w_dec_tens;
            w_ones_next = w_dec_ones;
            if (w_dec_zero) w_state_next = S_DONE;
          end
        end
      end
      S_PAUSED: begin
        if (bus.clear) begin
          w_state_next = S_IDLE;
          w_presc_next = '0;
          {w_min_next, w_tens_next, w_ones_next} = 12'h000;
        end else if (bus.start && bus.door_closed) begin
          w_state_next = S_COOKING;
          w_presc_next = '0;
        end
      end
      default: begin
        {w_min_next, w_tens_next, w_ones_next} = 12'h000;
        if (bus.clear || !bus.door_closed) w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ones   <= 4'd0;
      r_tens   <= 4'd0;
      r_min    <= 4'd0;
      r_presc  <= '0;
      r_mag_on <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ones   <= w_ones_next;
      r_tens   <= w_tens_next;
      r_min    <= w_min_next;
      r_presc  <= w_presc_next;
      r_mag_on <= (w_state_next == S_COOKING);
      r_done   <= (w_state_next == S_DONE);
    end
  end

  assign bus.sec_ones = r_ones;
  assign bus.sec_tens = r_tens;
  assign bus.min      = r_min;
  assign bus.mag_on   = r_mag_on;
  assign bus.done     = r_done;
  assign bus.state    = r_state;
endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
- Countdown timer controller for the microwave oven, one level above the 7-segment decoder.
- Holds the cook time as three BCD digits (min, sec_tens, sec_ones) and drives them directly into the decoder inputs.
- Accepts keypad digit entry and start/stop/clear commands, monitors the door, and sequences cooking with a 1-second prescaler.
- Asserts the magnetron enable while cooking and flags completion.

Parameters:
- TICKS_PER_SEC, default 100: clk cycles per 1-second countdown tick; must be >= 2.
- Prescaler counter width is $clog2(TICKS_PER_SEC).

Ports:
- clk  in  1  system clock; all logic updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- keypad_valid  in  1  one-cycle strobe qualifying keypad_digit.
- keypad_digit  in  4  BCD digit entered; values above 9 are invalid.
- start  in  1  start/resume request, level-sampled each cycle.
- stop  in  1  pause request.
- clear  in  1  cancel and zero the timer.
- door_closed  in  1  1 = door closed.
- sec_ones  out  4  BCD seconds ones digit, to the decoder.
- sec_tens  out  4  BCD seconds tens digit, to the decoder.
- min  out  4  BCD minutes digit, to the decoder.
- mag_on  out  1  magnetron enable.
- done  out  1  cook cycle finished.
- state  out  2  FSM state: IDLE=0, COOKING=1, PAUSED=2, DONE=3.

Behaviour:
- Reset:
  - Takes effect on the next clk edge while reset=1.
  - All digits 0, state IDLE, prescaler 0, mag_on 0, done 0.
  - Overrides everything, including mid-cook.
- Outputs: all registered; no combinational path from inputs to outputs.
  - mag_on = (state==COOKING).
  - done = (state==DONE).
- Keypad entry:
  - Accepted only in IDLE, with keypad_valid=1 and keypad_digit<=9.
  - Shift-left: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=keypad_digit.
  - The old min is discarded.
  - sec_tens values 6..9 are legal (e.g. 1:90).
  - Invalid digits and entries made in any other state are ignored.
- Priority within one cycle: reset > clear > door open > stop > start > tick > keypad.
- IDLE:
  - clear zeroes the digits.
  - start with door_closed=1 and time!=0:00 -> COOKING, prescaler cleared.
  - start with time==0:00 or door open is ignored.
- COOKING:
  - The prescaler increments every cycle.
  - tick = (prescaler==TICKS_PER_SEC-1); the prescaler then wraps to 0.
  - The first decrement therefore lands exactly TICKS_PER_SEC cycles after the COOKING entry edge.
  - On tick, decrement the BCD time:
    - sec_ones 0 -> 9 with a borrow into sec_tens; otherwise sec_ones-1.
    - sec_tens 0 -> 5 with a borrow into min; otherwise sec_tens-1.
    - min always decrements by 1 when borrowed from.
  - If the decremented value is 0:00, the same edge moves to DONE.
  - clear -> IDLE with the digits zeroed.
  - door_closed=0 or stop -> PAUSED: digits held, no decrement that cycle even if tick coincides.
  - keypad and start are ignored.
- PAUSED:
  - Digits and prescaler are held.
  - start with door_closed=1 -> COOKING, prescaler cleared, so a full period elapses before the next decrement.
  - clear -> IDLE, digits zeroed.
  - keypad ignored.
- DONE:
  - Digits are 0:00.
  - clear or door_closed=0 -> IDLE.
  - start and keypad are ignored.
- The decrement never underflows: COOKING is never entered with 0:00 and is left on reaching it.

Test Plan (TICKS_PER_SEC=4):
1. Reset, then keypad 1,3,0 on three strobes -> min=1, sec_tens=3, sec_ones=0, state=0; keypad 'hA gives no change; reset asserted gives 0:00.
2. Time 0:03, door closed, start pulse at cycle T -> state=1 and mag_on=1 at T+1; 0:02 at T+5, 0:01 at T+9, 0:00 with state=3, done=1, mag_on=0 at T+13; clear -> state=0, done=0.
3. Time 1:00 cooking -> after the first tick 0:59, then 0:58; entry 1,9,0 (1:90) -> ticks give 1:89, then 1:88.
4. 0:05 cooking, door_closed=0 after 6 cycles -> state=2, mag_on=0, digits 0:04 held for 20 cycles; start with door open ignored; door close + start -> 0:03 exactly 4 cycles after re-entry to COOKING. Stop asserted on a tick cycle -> PAUSED with no decrement.
5. Ignored inputs and clear:
   - start at 0:00 -> state stays 0.
   - keypad strobes during COOKING -> digits unchanged except by ticks.
   - clear in COOKING -> state=0, 0:00, mag_on=0.
   - clear+stop in the same cycle -> IDLE.
6. reset=1 for one cycle mid-cook at 0:42 -> next edge 0:00, state=0, mag_on=0, prescaler 0; a subsequent entry and start counts normally.
